quantize_stream: RTL

Multi-lane streaming requantizer that converts signed accumulator outputs to signed WIDTH_OUTPUT integers. The transform is a fixed-point multiplier, a rounding right-shift, zero-point add and saturation. It replaces the divide-based single-lane quantizer and sits between the matrix-multiply accumulator array and the activation buffer. It adds valid/ready backpressure, runtime scale/shift/zero-point, selectable rounding, per-lane saturation flags and burst framing (last/done).

---
 rtl/quant_pkg.sv | 25 ++
 rtl/quant_lane.sv | 79 +++++++
 rtl/quantize_stream.sv | 106 ++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared types and helpers for the streaming requantizer: rounding modes,
// config reset values and a width-generic saturation test.
package quant_pkg;

  typedef enum logic {
    ROUND_FLOOR     = 1'b0,
    ROUND_HALF_AWAY = 1'b1
  } round_e;

  localparam int unsigned RST_MULT  = 1;
  localparam int unsigned RST_SHIFT = 0;
  localparam int          RST_ZP    = 0;

  // Wide enough to hold any lane's post-zero-point value.
  localparam int SAT_W = 64;

  // Returns {above_max, below_min} for clamping v into a signed w-bit range.
  function automatic logic [1:0] sat_check(input logic signed [SAT_W-1:0] v,
                                           input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    return {v > hi, v < ~hi};
  endfunction

endpackage

// File: rtl/quant_lane.sv
// One lane of the requantizer: P1 multiply, P2 rounding shift,
// P3 zero-point add and saturate. All stages advance together.
module quant_lane
  import quant_pkg::*;
#(
  parameter int WIDTH_INPUT  = 32,
  parameter int WIDTH_OUTPUT = 8,
  parameter int MULT_W       = 16,
  parameter int SHIFT_W      = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           advance,
  input  logic signed [WIDTH_INPUT-1:0]  x,
  input  logic        [MULT_W-1:0]       mult,
  input  logic        [SHIFT_W-1:0]      shift,
  input  logic signed [WIDTH_OUTPUT-1:0] zp,
  input  round_e                         round_mode,
  output logic signed [WIDTH_OUTPUT-1:0] out,
  output logic                           sat
);

  localparam int PW = WIDTH_INPUT + MULT_W + 1;
  localparam int RW = PW + 1;
  localparam int VW = RW + 1;
  localparam logic signed [WIDTH_OUTPUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUTPUT-1){1'b1}}};
  localparam logic signed [WIDTH_OUTPUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUTPUT-1){1'b0}}};

  logic signed [PW-1:0]           xe, me, prod, p1;
  logic signed [RW-1:0]           pe, rnd_val, r2;
  logic        [RW-1:0]           mag, half, q;
  logic signed [VW-1:0]           v;
  logic        [1:0]              clip;
  logic signed [WIDTH_OUTPUT-1:0] out_n;
  logic                           sat_n;

  // M is unsigned, so it enters the signed product with a zero MSB.
  assign xe   = PW'(x);
  assign me   = $signed({{(PW-MULT_W){1'b0}}, mult});
  assign prod = xe * me;

  always_comb begin
    pe      = RW'(p1);
    mag     = pe[RW-1] ? -pe : pe;
    half    = (shift == '0) ? '0 : (RW'(1) << (shift - 1'b1));
    q       = (mag + half) >> shift;
    rnd_val = pe;
    if (shift == '0)
      rnd_val = pe;
    else if (round_mode == ROUND_FLOOR)
      rnd_val = pe >>> shift;
    else
      rnd_val = pe[RW-1] ? -$signed(q) : $signed(q);
  end

  always_comb begin
    v     = VW'(r2) + VW'(zp);
    clip  = sat_check(SAT_W'(v), WIDTH_OUTPUT);
    sat_n = |clip;
    out_n = v[WIDTH_OUTPUT-1:0];
    if (clip[1])      out_n = OUT_MAX;
    else if (clip[0]) out_n = OUT_MIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1  <= '0;
      r2  <= '0;
      out <= '0;
      sat <= 1'b0;
    end else if (advance) begin
      p1  <= prod;
      r2  <= rnd_val;
      out <= out_n;
      sat <= sat_n;
    end
  end

endmodule

// File: rtl/quantize_stream.sv
// Multi-lane streaming requantizer: valid/stall control, runtime config
// registers, burst framing (last/done) around LANES quant_lane datapaths.
module quantize_stream
  import quant_pkg::*;
#(
  parameter int WIDTH_INPUT   = 32,
  parameter int WIDTH_OUTPUT  = 8,
  parameter int LANES         = 4,
  parameter int MULT_W        = 16,
  parameter int SHIFT_W       = 5,
  parameter int NUM_CALCULATE = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          cfg_we_i,
  input  logic [MULT_W-1:0]             cfg_mult_i,
  input  logic [SHIFT_W-1:0]            cfg_shift_i,
  input  logic [WIDTH_OUTPUT-1:0]       cfg_zp_i,
  input  logic                          cfg_round_i,
  output logic                          cfg_busy_o,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [LANES*WIDTH_INPUT-1:0]  s_data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [LANES*WIDTH_OUTPUT-1:0] m_data_o,
  output logic [LANES-1:0]              m_sat_o,
  output logic                          m_last_o,
  output logic                          done_o
);

  localparam int STAGES = 3;
  localparam int CNT_W  = (NUM_CALCULATE > 2) ? $clog2(NUM_CALCULATE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CALCULATE - 1);

  logic [STAGES:1]                vld_pipe;
  logic                           advance, out_fire, last_fire;
  logic [CNT_W-1:0]               beat_cnt;
  logic [MULT_W-1:0]              cfg_mult;
  logic [SHIFT_W-1:0]             cfg_shift;
  logic signed [WIDTH_OUTPUT-1:0] cfg_zp;
  round_e                         cfg_round;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign advance    = !m_valid_o || m_ready_i;
  assign s_ready_o  = advance;
  assign m_valid_o  = vld_pipe[STAGES];
  assign out_fire   = m_valid_o && m_ready_i;
  assign last_fire  = out_fire && (beat_cnt == LAST_CNT);
  assign m_last_o   = m_valid_o && (beat_cnt == LAST_CNT);
  assign cfg_busy_o = (beat_cnt != '0) || (|vld_pipe);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      vld_pipe <= '0;
    else if (advance)
      vld_pipe <= {vld_pipe[STAGES-1:1], s_valid_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beat_cnt <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= last_fire;
      if (out_fire)
        beat_cnt <= last_fire ? '0 : beat_cnt + 1'b1;
    end
  end

  // Config only changes between bursts, so every stage may read it live.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_mult  <= MULT_W'(RST_MULT);
      cfg_shift <= SHIFT_W'(RST_SHIFT);
      cfg_zp    <= WIDTH_OUTPUT'(RST_ZP);
      cfg_round <= ROUND_HALF_AWAY;
    end else if (cfg_we_i && !cfg_busy_o) begin
      cfg_mult  <= cfg_mult_i;
      cfg_shift <= cfg_shift_i;
      cfg_zp    <= cfg_zp_i;
      cfg_round <= round_e'(cfg_round_i);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    quant_lane #(
      .WIDTH_INPUT (WIDTH_INPUT),
      .WIDTH_OUTPUT(WIDTH_OUTPUT),
      .MULT_W      (MULT_W),
      .SHIFT_W     (SHIFT_W)
    ) u_lane (
      .clk       (clk_i),
      .rst_n     (rstn_i),
      .advance   (advance),
      .x         (s_data_i[k*WIDTH_INPUT +: WIDTH_INPUT]),
      .mult      (cfg_mult),
      .shift     (cfg_shift),
      .zp        (cfg_zp),
      .round_mode(cfg_round),
      .out       (m_data_o[k*WIDTH_OUTPUT +: WIDTH_OUTPUT]),
      .sat       (m_sat_o[k])
    );
  end

endmodule
